// File: rtl/itrx_aib_phy_seq_pkg.sv
// Shared types and constants for the AIB PHY link bring-up sequencer.
package itrx_aib_phy_seq_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DETECT    = 3'd1,
    ST_PHY_REL   = 3'd2,
    ST_WAIT_PEER = 3'd3,
    ST_ADAP_REL  = 3'd4,
    ST_CAL       = 3'd5,
    ST_LINK_UP   = 3'd6,
    ST_ERROR     = 3'd7
  } seq_state_e;

endpackage

// File: rtl/itrx_aib_phy_bit_sync.sv
// Multi-flop single-bit synchronizer, asynchronously cleared to 0.
module itrx_aib_phy_bit_sync
  import itrx_aib_phy_seq_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/itrx_aib_phy_link_seq.sv
// AIB PHY channel bring-up sequencer: ordered reset release, step timeouts,
// bounded retries, Moore-registered outputs.
module itrx_aib_phy_link_seq
  import itrx_aib_phy_seq_pkg::*;
#(
  parameter int unsigned TMR_W     = 32'd16,
  parameter int unsigned T_SETTLE  = 32'd1000,
  parameter int unsigned T_TIMEOUT = 32'd50000,
  parameter int unsigned NRETRY    = 32'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ms_nsl,
  input  logic       por_out,
  input  logic       device_detect,
  input  logic       rstn_out,
  input  logic       adap_rstn_out,
  input  logic       dll_lock,
  output logic       phy_rstn,
  output logic       adap_rstn,
  output logic       adapt_rstn,
  output logic       dll_lock_req,
  output logic       link_up,
  output logic       link_err,
  output logic [2:0] seq_state,
  output logic [3:0] retry_cnt
);

  localparam logic [TMR_W-1:0] SETTLE_M1  = TMR_W'(T_SETTLE - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_M1 = TMR_W'(T_TIMEOUT - 1);
  localparam logic [3:0]       NRETRY_V   = 4'(NRETRY);

  logic [4:0] stat_raw;
  logic [4:0] stat_s;

  assign stat_raw = {dll_lock, adap_rstn_out, rstn_out, device_detect, por_out};

  for (genvar g = 0; g < 5; g++) begin : g_sync
    itrx_aib_phy_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (stat_raw[g]),
      .q_o   (stat_s[g])
    );
  end

  logic por_out_s, device_detect_s, rstn_out_s, adap_rstn_out_s, dll_lock_s;
  logic detect_ok;

  assign {dll_lock_s, adap_rstn_out_s, rstn_out_s, device_detect_s, por_out_s} = stat_s;
  assign detect_ok = ms_nsl ? ~por_out_s : device_detect_s;

  seq_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic [3:0]       retry_q, retry_d;
  logic [5:0]       outs_q, outs_d;
  logic             fail;

  assign tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_inc;
    retry_d = retry_q;
    fail    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_DETECT;
      end
      ST_DETECT: begin
        if (!detect_ok)              tmr_d   = '0;
        else if (tmr_q == SETTLE_M1) state_d = ST_PHY_REL;
      end
      ST_PHY_REL: begin
        state_d = ST_WAIT_PEER;
      end
      ST_WAIT_PEER: begin
        if (rstn_out_s)               state_d = ST_ADAP_REL;
        else if (tmr_q == TIMEOUT_M1) fail    = 1'b1;
      end
      ST_ADAP_REL: begin
        if (adap_rstn_out_s)          state_d = ST_CAL;
        else if (tmr_q == TIMEOUT_M1) fail    = 1'b1;
      end
      ST_CAL: begin
        if (dll_lock_s)               state_d = ST_LINK_UP;
        else if (tmr_q == TIMEOUT_M1) fail    = 1'b1;
      end
      ST_LINK_UP: begin
        if (!detect_ok || !rstn_out_s || !adap_rstn_out_s || !dll_lock_s) fail = 1'b1;
      end
      ST_ERROR: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      retry_d = retry_q + 4'd1;
      state_d = (retry_d == NRETRY_V) ? ST_ERROR : ST_DETECT;
    end

    // Abort overrides everything; IDLE entry also clears the bookkeeping so
    // retry_cnt reads 0 on the first IDLE cycle rather than one cycle later.
    if (!enable) state_d = ST_IDLE;
    if (state_d == ST_IDLE) retry_d = '0;
    if (state_d != state_q || state_d == ST_IDLE) tmr_d = '0;
  end

  // Output word: {phy_rstn, adap_rstn, adapt_rstn, dll_lock_req, link_up, link_err}
  always_comb begin
    outs_d = '0;
    unique case (state_d)
      ST_PHY_REL, ST_WAIT_PEER: outs_d = 6'b100000;
      ST_ADAP_REL:              outs_d = 6'b111000;
      ST_CAL:                   outs_d = 6'b111100;
      ST_LINK_UP:               outs_d = 6'b111110;
      ST_ERROR:                 outs_d = 6'b000001;
      default:                  outs_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      retry_q <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      outs_q  <= outs_d;
    end
  end

  assign {phy_rstn, adap_rstn, adapt_rstn, dll_lock_req, link_up, link_err} = outs_q;
  assign seq_state = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_itrx_aib_phy_link_seq.sv
// Bench for itrx_aib_phy_link_seq with a behavioural PHY peer.
module tb_itrx_aib_phy_link_seq;

  localparam int unsigned TS = 20;
  localparam int unsigned TT = 100;
  localparam int unsigned NR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic ms_nsl = 1'b1;
  logic por_out = 1'b0;
  logic device_detect = 1'b0;
  logic en_r = 1'b1, en_a = 1'b1, en_d = 1'b1;
  logic rstn_out, adap_rstn_out, dll_lock;
  logic phy_rstn, adap_rstn, adapt_rstn, dll_lock_req, link_up, link_err;
  logic [2:0] seq_state;
  logic [3:0] retry_cnt;

  int unsigned rc = 0, ac = 0, dc = 0, cyc = 0;
  int unsigned n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rc  <= phy_rstn     ? ((rc < 1000) ? rc + 1 : rc) : 0;
    ac  <= adapt_rstn   ? ((ac < 1000) ? ac + 1 : ac) : 0;
    dc  <= dll_lock_req ? ((dc < 1000) ? dc + 1 : dc) : 0;
  end

  assign rstn_out      = en_r && (rc >= 10);
  assign adap_rstn_out = en_a && (ac >= 10);
  assign dll_lock      = en_d && (dc >= 20);

  itrx_aib_phy_link_seq #(
    .TMR_W(16), .T_SETTLE(TS), .T_TIMEOUT(TT), .NRETRY(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ms_nsl(ms_nsl),
    .por_out(por_out), .device_detect(device_detect), .rstn_out(rstn_out),
    .adap_rstn_out(adap_rstn_out), .dll_lock(dll_lock),
    .phy_rstn(phy_rstn), .adap_rstn(adap_rstn), .adapt_rstn(adapt_rstn),
    .dll_lock_req(dll_lock_req), .link_up(link_up), .link_err(link_err),
    .seq_state(seq_state), .retry_cnt(retry_cnt)
  );

  typedef struct {
    logic [2:0]  st;
    logic [5:0]  outs;
    logic [3:0]  retry;
    int unsigned budget;
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];

  function automatic logic [5:0] outs_now();
    return {phy_rstn, adap_rstn, adapt_rstn, dll_lock_req, link_up, link_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int unsigned budget, output bit ok);
    int unsigned n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      if (seq_state == st) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) chk($sformatf("wait_state_%0d_expired", st), {29'd0, seq_state}, {29'd0, st});
  endtask

  task automatic pop_check(output int unsigned t);
    vec_t e;
    bit ok;
    e = sb_q.pop_front();
    wait_state(e.st, e.budget, ok);
    t = cyc;
    if (ok) begin
      chk($sformatf("outs_st%0d", e.st), {26'd0, outs_now()}, {26'd0, e.outs});
      chk($sformatf("retry_st%0d", e.st), {28'd0, retry_cnt}, {28'd0, e.retry});
    end
  endtask

  initial begin
    bit ok;
    int unsigned t0, t1, k;

    vecs[0] = '{3'd1, 6'b000000, 4'd0, 10};
    vecs[1] = '{3'd2, 6'b100000, 4'd0, TS + 5};
    vecs[2] = '{3'd3, 6'b100000, 4'd0, 5};
    vecs[3] = '{3'd4, 6'b111000, 4'd0, 20};
    vecs[4] = '{3'd5, 6'b111100, 4'd0, 20};
    vecs[5] = '{3'd6, 6'b111110, 4'd0, 30};

    // Reset values
    #12;
    chk("rst_state", {29'd0, seq_state}, 32'd0);
    chk("rst_outs", {26'd0, outs_now()}, 32'd0);
    chk("rst_retry", {28'd0, retry_cnt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", {29'd0, seq_state}, 32'd0);

    // Master bring-up, table driven through the scoreboard
    enable = 1'b1;
    for (int i = 0; i < 6; i++) sb_q.push_back(vecs[i]);
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      pop_check(t1);
      if (i == 0) t0 = t1;
      if (i == 1) chk("detect_len", t1 - t0, TS);
    end

    // dll_lock drops in LINK_UP: 2 sync cycles + 1 state cycle
    en_d = 1'b0;
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!link_up && k == 0) k = i;
    end
    chk("dll_drop_latency", k, 3);
    chk("dll_drop_state", {29'd0, seq_state}, 32'd1);
    chk("dll_drop_outs", {26'd0, outs_now()}, 32'd0);
    chk("dll_drop_retry", {28'd0, retry_cnt}, 32'd1);
    en_d = 1'b1;
    wait_state(3'd6, TS + 100, ok);
    chk("rebuild_link_up", {31'd0, link_up}, 32'd1);
    chk("rebuild_retry", {28'd0, retry_cnt}, 32'd1);

    // enable dropped in CAL
    enable = 1'b0;
    wait_state(3'd0, 3, ok);
    en_d = 1'b0;
    enable = 1'b1;
    wait_state(3'd5, TS + 60, ok);
    chk("cal_retry_before", {28'd0, retry_cnt}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_state", {29'd0, seq_state}, 32'd0);
    chk("abort_dll_req", {31'd0, dll_lock_req}, 32'd0);
    chk("abort_retry", {28'd0, retry_cnt}, 32'd0);
    en_d = 1'b1;

    // Slave with a detect glitch part-way through settling
    ms_nsl = 1'b0;
    device_detect = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_state(3'd1, 5, ok);
    repeat (10) @(negedge clk);
    device_detect = 1'b0;
    repeat (2) @(negedge clk);
    device_detect = 1'b1;
    t0 = cyc;
    wait_state(3'd2, TS + 10, ok);
    chk("glitch_restart", cyc - t0, TS + 2);
    wait_state(3'd6, 80, ok);
    chk("slave_link_up", {31'd0, link_up}, 32'd1);

    // Peer never releases: three timeouts then ERROR
    enable = 1'b0;
    wait_state(3'd0, 3, ok);
    ms_nsl = 1'b1;
    en_r = 1'b0;
    enable = 1'b1;
    wait_state(3'd3, TS + 10, ok);
    t0 = cyc;
    wait_state(3'd1, TT + 5, ok);
    chk("timeout_len", cyc - t0, TT);
    chk("timeout_retry1", {28'd0, retry_cnt}, 32'd1);
    wait_state(3'd7, 2 * (TS + TT + 10), ok);
    chk("err_outs", {26'd0, outs_now()}, 32'b000001);
    chk("err_retry", {28'd0, retry_cnt}, NR);
    repeat (5) @(negedge clk);
    chk("err_hold", {29'd0, seq_state}, 32'd7);
    enable = 1'b0;
    wait_state(3'd0, 3, ok);
    chk("err_exit_retry", {28'd0, retry_cnt}, 32'd0);

    // Async reset in ADAP_REL
    en_r = 1'b1;
    en_a = 1'b0;
    enable = 1'b1;
    wait_state(3'd4, TS + 40, ok);
    chk("adap_outs", {26'd0, outs_now()}, 32'b111000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {26'd0, outs_now()}, 32'd0);
    chk("async_rst_state", {29'd0, seq_state}, 32'd0);
    chk("async_rst_retry", {28'd0, retry_cnt}, 32'd0);
    en_a = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    wait_state(3'd1, 5, ok);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
